trigger_pulse_gen: RTL

TRIGGER_PULSE_GEN -- requirements
Module: trigger_pulse_gen

---
 rtl/trigger_pkg.sv | 15 +
 rtl/trigger_channel.sv | 131 +++++++++++++
 rtl/trigger_pulse_gen.sv | 52 +++++
 3 files changed

// File: rtl/trigger_pkg.sv
// Shared types and constants for the trigger pulse generator.
`timescale 1ns/1ps
package trigger_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_PULSE = 2'd2,
      ST_REARM = 2'd3
   } trig_state_e;

   localparam int DEF_CNT_W  = 32;
   localparam int DEF_NUM_CH = 4;

endpackage

// File: rtl/trigger_channel.sv
// One trigger channel: synchronizer, edge detect, delay/width FSM.
`timescale 1ns/1ps
module trigger_channel
   import trigger_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_trig,
   input  logic             i_enable,
   input  logic [CNT_W-1:0] i_delay,
   input  logic [CNT_W-1:0] i_width,
   input  logic             i_retrig,
   output logic             o_pulse,
   output logic             o_busy,
   output logic             o_miss
);

   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_prev;
   logic             r_rise;
   logic [1:0]       r_vld;
   trig_state_e      r_state;
   trig_state_e      w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt;
   logic [CNT_W-1:0] r_wlat;
   logic [CNT_W-1:0] w_wlat;
   logic [CNT_W-1:0] w_wsat;
   logic             r_pulse;
   logic             r_busy;
   logic             w_miss;

   assign w_wsat = (i_width == '0) ? C_ONE : i_width;

   // r_prev holds 1 until the synchronizer has refilled after reset,
   // so a level already high at release is not seen as a rise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_vld   <= 2'b00;
         r_prev  <= 1'b1;
         r_rise  <= 1'b0;
      end else begin
         r_sync1 <= i_trig;
         r_sync2 <= r_sync1;
         r_vld   <= {r_vld[0], 1'b1};
         if (r_vld[1])
            r_prev <= r_sync2;
         r_rise  <= r_sync2 & ~r_prev;
      end
   end

   always_comb begin
      w_next = r_state;
      w_cnt  = r_cnt;
      w_wlat = r_wlat;
      w_miss = 1'b0;
      if (!i_enable) begin
         w_next = ST_IDLE;
         w_cnt  = '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (r_rise) begin
                  w_wlat = w_wsat;
                  if (i_delay != '0) begin
                     w_next = ST_DELAY;
                     w_cnt  = i_delay;
                  end else begin
                     w_next = ST_PULSE;
                     w_cnt  = w_wsat;
                  end
               end
            end
            ST_DELAY: begin
               w_miss = r_rise;
               if (r_cnt == C_ONE) begin
                  w_next = ST_PULSE;
                  w_cnt  = r_wlat;
               end else begin
                  w_cnt = r_cnt - C_ONE;
               end
            end
            ST_PULSE: begin
               if (r_rise && i_retrig) begin
                  w_cnt = r_wlat;
               end else begin
                  w_miss = r_rise;
                  if (r_cnt == C_ONE) begin
                     w_next = ST_REARM;
                     w_cnt  = '0;
                  end else begin
                     w_cnt = r_cnt - C_ONE;
                  end
               end
            end
            ST_REARM: begin
               if (!r_sync2)
                  w_next = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_wlat  <= '0;
         r_pulse <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt;
         r_wlat  <= w_wlat;
         r_pulse <= (w_next == ST_PULSE);
         r_busy  <= (w_next != ST_IDLE);
      end
   end

   assign o_pulse = r_pulse;
   assign o_busy  = r_busy;
   assign o_miss  = w_miss;

endmodule

// File: rtl/trigger_pulse_gen.sv
// Multi-channel delayed trigger pulse generator with sticky missed flags.
`timescale 1ns/1ps
module trigger_pulse_gen
   import trigger_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] trigger_in,
   input  logic [NUM_CH-1:0] ch_enable,
   input  logic [CNT_W-1:0]  delay_cycles,
   input  logic [CNT_W-1:0]  width_cycles,
   input  logic              retrigger_en,
   input  logic              clear_missed,
   output logic [NUM_CH-1:0] trigger_out,
   output logic [NUM_CH-1:0] busy,
   output logic [NUM_CH-1:0] missed
);

   logic [NUM_CH-1:0] w_miss;
   logic [NUM_CH-1:0] r_missed;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      trigger_channel #(
         .CNT_W(CNT_W)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .i_trig  (trigger_in[g]),
         .i_enable(ch_enable[g]),
         .i_delay (delay_cycles),
         .i_width (width_cycles),
         .i_retrig(retrigger_en),
         .o_pulse (trigger_out[g]),
         .o_busy  (busy[g]),
         .o_miss  (w_miss[g])
      );
   end

   // A new miss on the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_missed <= '0;
      else
         r_missed <= w_miss | (r_missed & ~{NUM_CH{clear_missed}});
   end

   assign missed = r_missed;

endmodule
